// File: rtl/ascon_pkg.sv
// Shared constants, FSM encoding and helpers for the Ascon permutation block.
// Includes the expected round-constant function used by ASCON_PERM_RCON_CHECK_EN.
package ascon_pkg;

    localparam int STATE_W    = 320;
    localparam int WORD_W     = 64;
    localparam int MAX_ROUNDS = 12;

    localparam int ROT_X0_A = 19;
    localparam int ROT_X0_B = 28;
    localparam int ROT_X1_A = 61;
    localparam int ROT_X1_B = 39;
    localparam int ROT_X2_A = 1;
    localparam int ROT_X2_B = 6;
    localparam int ROT_X3_A = 10;
    localparam int ROT_X3_B = 17;
    localparam int ROT_X4_A = 7;
    localparam int ROT_X4_B = 41;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } perm_state_e;

    // Constant for round i is (15-i) in the high nibble and i in the low nibble.
    function automatic logic [7:0] exp_rcon(input logic [3:0] idx);
        return {4'hF - idx, idx};
    endfunction

    function automatic logic [WORD_W-1:0] rotr64(input logic [WORD_W-1:0] v, input int unsigned n);
        return (v >> n) | (v << (WORD_W - n));
    endfunction

endpackage

// File: rtl/ascon_permutation_if.sv
// Handshake and data bundle between the permutation block and its upstream driver.
// rcon_err is present only when ASCON_PERM_RCON_CHECK_EN is defined.
interface ascon_permutation_if;
    import ascon_pkg::*;

    logic               start;
    logic [3:0]         rounds;
    logic [STATE_W-1:0] state_in;
    logic [7:0]         r_con;
    logic [3:0]         round_idx;
    logic               busy;
    logic               done;
    logic [STATE_W-1:0] state_out;

`ifdef ASCON_PERM_RCON_CHECK_EN
    logic               rcon_err;

    modport master (
        output start, rounds, state_in, r_con,
        input  round_idx, busy, done, state_out, rcon_err
    );

    modport slave (
        input  start, rounds, state_in, r_con,
        output round_idx, busy, done, state_out, rcon_err
    );
`else
    modport master (
        output start, rounds, state_in, r_con,
        input  round_idx, busy, done, state_out
    );

    modport slave (
        input  start, rounds, state_in, r_con,
        output round_idx, busy, done, state_out
    );
`endif

endinterface

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bit-sliced 5-bit S-box,
// then the per-word linear diffusion layer.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [STATE_W-1:0] i_state,
    input  logic [7:0]         i_rcon,
    output logic [STATE_W-1:0] o_state
);

    logic [WORD_W-1:0] w_x0, w_x1, w_x2, w_x3, w_x4;
    logic [WORD_W-1:0] w_a0, w_a1, w_a2, w_a3, w_a4;
    logic [WORD_W-1:0] w_b0, w_b1, w_b2, w_b3, w_b4;
    logic [WORD_W-1:0] w_s0, w_s1, w_s2, w_s3, w_s4;
    logic [WORD_W-1:0] w_l0, w_l1, w_l2, w_l3, w_l4;

    assign w_x0 = i_state[319:256];
    assign w_x1 = i_state[255:192];
    assign w_x2 = i_state[191:128] ^ {56'd0, i_rcon};
    assign w_x3 = i_state[127:64];
    assign w_x4 = i_state[63:0];

    // S-box input mixing
    assign w_a0 = w_x0 ^ w_x4;
    assign w_a1 = w_x1;
    assign w_a2 = w_x2 ^ w_x1;
    assign w_a3 = w_x3;
    assign w_a4 = w_x4 ^ w_x3;

    // Chi-like nonlinear core
    assign w_b0 = w_a0 ^ (~w_a1 & w_a2);
    assign w_b1 = w_a1 ^ (~w_a2 & w_a3);
    assign w_b2 = w_a2 ^ (~w_a3 & w_a4);
    assign w_b3 = w_a3 ^ (~w_a4 & w_a0);
    assign w_b4 = w_a4 ^ (~w_a0 & w_a1);

    assign w_s0 = w_b0 ^ w_b4;
    assign w_s1 = w_b1 ^ w_b0;
    assign w_s2 = ~w_b2;
    assign w_s3 = w_b3 ^ w_b2;
    assign w_s4 = w_b4;

    assign w_l0 = w_s0 ^ rotr64(w_s0, ROT_X0_A) ^ rotr64(w_s0, ROT_X0_B);
    assign w_l1 = w_s1 ^ rotr64(w_s1, ROT_X1_A) ^ rotr64(w_s1, ROT_X1_B);
    assign w_l2 = w_s2 ^ rotr64(w_s2, ROT_X2_A) ^ rotr64(w_s2, ROT_X2_B);
    assign w_l3 = w_s3 ^ rotr64(w_s3, ROT_X3_A) ^ rotr64(w_s3, ROT_X3_B);
    assign w_l4 = w_s4 ^ rotr64(w_s4, ROT_X4_A) ^ rotr64(w_s4, ROT_X4_B);

    assign o_state = {w_l0, w_l1, w_l2, w_l3, w_l4};

endmodule

// File: rtl/ascon_permutation.sv
// Iterative Ascon permutation, one round per clock, N = 1..12 rounds per run.
// Optional feature macro: ASCON_PERM_RCON_CHECK_EN adds a sticky round-constant checker.
module ascon_permutation
    import ascon_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    ascon_permutation_if.slave bus
);

    perm_state_e        r_state;
    perm_state_e        w_state_nxt;
    logic [STATE_W-1:0] r_state_reg;
    logic [STATE_W-1:0] r_state_out;
    logic [3:0]         r_round_idx;
    logic [3:0]         w_first_idx;
    logic               w_last;
    logic [STATE_W-1:0] w_round_out;

    ascon_round u_round (
        .i_state (r_state_reg),
        .i_rcon  (bus.r_con),
        .o_state (w_round_out)
    );

    // Out-of-range round counts fall back to the full 12-round permutation.
    assign w_first_idx = (bus.rounds == 4'd0 || bus.rounds > 4'(MAX_ROUNDS))
                         ? 4'd0 : 4'(MAX_ROUNDS) - bus.rounds;
    assign w_last      = (r_round_idx == 4'(MAX_ROUNDS - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_state_reg <= '0;
            r_state_out <= '0;
            r_round_idx <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state_reg <= bus.state_in;
                        r_round_idx <= w_first_idx;
                    end
                end
                ST_RUN: begin
                    r_state_reg <= w_round_out;
                    if (w_last) begin
                        r_round_idx <= 4'd0;
                        r_state_out <= w_round_out;
                    end else begin
                        r_round_idx <= r_round_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ASCON_PERM_RCON_CHECK_EN
    logic r_rcon_err;

    // Flags only; the datapath still consumes the incoming constant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rcon_err <= 1'b0;
        end else if (r_state == ST_RUN && bus.r_con != exp_rcon(r_round_idx)) begin
            r_rcon_err <= 1'b1;
        end
    end

    assign bus.rcon_err = r_rcon_err;
`endif

    assign bus.round_idx = r_round_idx;
    assign bus.busy      = (r_state == ST_RUN);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.state_out = r_state_out;

endmodule

// File: tb/tb_ascon_permutation.sv
// Scoreboard bench for ascon_permutation: randomized runs against a table-driven
// S-box reference model; a monitor checks every done pulse against queued results.
module tb_ascon_permutation;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ascon_permutation_if ifc();

    ascon_permutation dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct {
        logic [319:0] st;
        int           cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   bad_idx_drv = -1;
    logic exp_err  = 1'b0;

    logic [7:0] rc_tab [16] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87,
                                8'h78, 8'h69, 8'h5A, 8'h4B, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [4:0] sbox [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                              5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                              5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                              5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    int rot_a [5] = '{19, 61, 1, 10, 7};
    int rot_b [5] = '{28, 39, 6, 17, 41};

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream constant stage: table lookup by round_idx, optionally corrupted.
    always_comb begin
        ifc.r_con = rc_tab[ifc.round_idx];
        if (ifc.busy && int'(ifc.round_idx) == bad_idx_drv) ifc.r_con = 8'h00;
    end

    function automatic logic [63:0] ror(input logic [63:0] v, input int r);
        return (v >> r) | (v << (64 - r));
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s, input int n, input int bad);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v;
        logic [4:0]  o;
        for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
        for (int r = 12 - n; r < 12; r++) begin
            x[2] = x[2] ^ {56'd0, (r == bad) ? 8'h00 : rc_tab[r]};
            for (int j = 0; j < 64; j++) begin
                v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                o = sbox[v];
                for (int w = 0; w < 5; w++) y[w][j] = o[4 - w];
            end
            for (int w = 0; w < 5; w++) x[w] = y[w] ^ ror(y[w], rot_a[w]) ^ ror(y[w], rot_b[w]);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [319:0] rnd_state();
        logic [319:0] s;
        for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic chk_err(input string name);
`ifdef ASCON_PERM_RCON_CHECK_EN
        chk(name, ifc.rcon_err, exp_err);
`endif
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ifc.done) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("state_out", ifc.state_out, e.st);
                chk("done_cycle", 320'(cyc), 320'(e.cyc));
            end
        end
    end

    task automatic run_perm(input logic [3:0] rnds, input logic [319:0] st, input int bad);
        int n;
        int first;
        n     = (rnds == 4'd0 || rnds > 4'd12) ? 12 : int'(rnds);
        first = 12 - n;
        bad_idx_drv  = bad;
        ifc.start    = 1'b1;
        ifc.rounds   = rnds;
        ifc.state_in = st;
        @(posedge clk); #1;
        sbq.push_back('{st: model_perm(st, n, bad), cyc: cyc + n});
        for (int k = 0; k < n; k++) begin
            chk("busy_run", ifc.busy, 1'b1);
            chk("round_idx", ifc.round_idx, 320'(first + k));
            chk("r_con", ifc.r_con, (first + k == bad) ? 320'h0 : 320'(rc_tab[first + k]));
            chk_err("rcon_err_run");
            if (first + k == bad) exp_err = 1'b1;
            ifc.start    = 1'($urandom);
            ifc.rounds   = 4'($urandom);
            ifc.state_in = rnd_state();
            @(posedge clk); #1;
        end
        chk("busy_done", ifc.busy, 1'b0);
        chk("idx_done", ifc.round_idx, 320'h0);
        chk("done_pulse", ifc.done, 1'b1);
        chk_err("rcon_err_done");
        ifc.start = 1'($urandom);
        @(posedge clk); #1;
        ifc.start = 1'b0;
        chk("done_cleared", ifc.done, 1'b0);
        chk("busy_idle", ifc.busy, 1'b0);
        bad_idx_drv = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [319:0] st_at [28];
        rst          = 1'b1;
        ifc.start    = 1'b0;
        ifc.rounds   = 4'd0;
        ifc.state_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", ifc.busy, 1'b0);
        chk("rst_done", ifc.done, 1'b0);
        chk("rst_idx", ifc.round_idx, 320'h0);
        chk("rst_state_out", ifc.state_out, 320'h0);
        chk_err("rst_rcon_err");
        rst = 1'b0;

        run_perm(4'd12, 320'h0, -1);
        run_perm(4'd6, rnd_state(), -1);
        run_perm(4'd8, rnd_state(), -1);
        run_perm(4'd0, rnd_state(), -1);
        run_perm(4'd15, rnd_state(), -1);
        for (int i = 0; i < 6; i++) run_perm(4'($urandom), rnd_state(), -1);

        // start held high: exactly two runs, state_in churning every cycle
        ifc.start  = 1'b1;
        ifc.rounds = 4'd12;
        for (int e = 0; e < 28; e++) begin
            st_at[e] = rnd_state();
            ifc.state_in = st_at[e];
            @(posedge clk); #1;
            if (e == 0 || e == 14) sbq.push_back('{st: model_perm(st_at[e], 12, -1), cyc: cyc + 12});
        end
        ifc.start = 1'b0;
        @(posedge clk); #1;

        run_perm(4'd12, rnd_state(), 3);
        run_perm(4'd5, rnd_state(), -1);

        // reset during RUN cycle 5 aborts without a done pulse
        ifc.start    = 1'b1;
        ifc.rounds   = 4'd12;
        ifc.state_in = rnd_state();
        @(posedge clk); #1;
        ifc.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", ifc.busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_err = 1'b0;
        chk("abort_busy", ifc.busy, 1'b0);
        chk("abort_done", ifc.done, 1'b0);
        chk("abort_state_out", ifc.state_out, 320'h0);
        chk("abort_idx", ifc.round_idx, 320'h0);
        chk_err("abort_rcon_err");

        run_perm(4'd12, rnd_state(), -1);
        run_perm(4'd3, rnd_state(), -1);

        repeat (20) @(posedge clk);
        #1;
        chk("queue_drained", 320'(sbq.size()), 320'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
